// File: rtl/nic_inject_eject.sv
// nic_inject_eject
//   Local network interface on router port 0.
//   Injection: core messages are queued, stamped with an output VC picked
//   round-robin among VCs that still hold credit, and driven to the router
//   one flit per cycle. Ejection: the router's local output is registered
//   and handed to the core with the VC field removed.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   core_valid/ready    core message handshake (ready = queue not full)
//   core_dest/payload   message fields
//   inj_data/inj_valid  flit to router input_data[0]/input_valid[0]
//   credit_in           one pulse per freed local-port VC slot, per VC
//   eject_data_in/valid_in  router out_data[0]/out_valid[0]
//   eject_valid/dest/payload  registered ejected flit to the core
//   credit_err          sticky: credit returned to an already-full counter
//
// Build option
//   NIC_STATS_EN  adds inj_count, ej_count (32-bit, wrapping) and
//                 stall_cycles (16-bit, saturating BLOCKED-cycle count).
//
// state     | meaning
// S_IDLE    | injection queue empty, nothing to send
// S_SEND    | queue head present; sends it on the next VC with credit
// S_BLOCKED | queue non-empty, every VC out of credit; waits for credit_in

`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module nic_inject_eject #(
  parameter int NUM_VC         = 4,
  parameter int NUM_ROUTERS    = 16,
  parameter int BUFFER_DEPTH   = 8,
  parameter int INJ_DEPTH      = 4,
  parameter int VC_BITS        = $clog2(NUM_VC),
  parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
  parameter int CR_BITS        = $clog2(BUFFER_DEPTH) + 1,
  parameter int PAYLOAD_W      = `FLIT_DATA_WIDTH - VC_BITS - ROUTER_ID_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        core_valid,
  output logic                        core_ready,
  input  logic [ROUTER_ID_BITS-1:0]   core_dest,
  input  logic [PAYLOAD_W-1:0]        core_payload,
  output logic [`FLIT_DATA_WIDTH-1:0] inj_data,
  output logic                        inj_valid,
  input  logic [NUM_VC-1:0]           credit_in,
  input  logic [`FLIT_DATA_WIDTH-1:0] eject_data_in,
  input  logic                        eject_valid_in,
  output logic                        eject_valid,
  output logic [ROUTER_ID_BITS-1:0]   eject_dest,
  output logic [PAYLOAD_W-1:0]        eject_payload,
`ifdef NIC_STATS_EN
  output logic [31:0]                 inj_count,
  output logic [31:0]                 ej_count,
  output logic [15:0]                 stall_cycles,
`endif
  output logic                        credit_err
);

  localparam int FLIT_W = `FLIT_DATA_WIDTH;
  localparam int PTR_W  = $clog2(INJ_DEPTH);
  localparam int MSG_W  = ROUTER_ID_BITS + PAYLOAD_W;

  localparam logic [CR_BITS-1:0] CR_MAX = CR_BITS'(BUFFER_DEPTH);
  localparam logic [CR_BITS-1:0] CR_ONE = CR_BITS'(1);
  localparam logic [PTR_W:0]     Q_FULL = (PTR_W+1)'(INJ_DEPTH);
  localparam logic [PTR_W:0]     Q_ONE  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_BLOCKED} state_t;

  state_t state;

  // ---------------- injection queue ----------------
  logic [MSG_W-1:0] q_mem [INJ_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   q_count, q_count_next;
  logic             q_full, push, pop;

  // ---------------- credits / VC selection ----------------
  logic [CR_BITS-1:0] credit_cnt [NUM_VC];
  logic [CR_BITS-1:0] credit_nxt [NUM_VC];
  logic [VC_BITS-1:0] rr_ptr, pick_vc, rr_nxt;
  logic               any_credit, any_credit_next, credit_set_err, send;
  logic [NUM_VC-1:0]  send_hit;

  assign q_full     = (q_count == Q_FULL);
  assign core_ready = !q_full;
  assign push       = core_valid && !q_full;
  assign pop        = send;

  always_comb begin
    q_count_next = q_count;
    if (push && !pop)      q_count_next = q_count + Q_ONE;
    else if (!push && pop) q_count_next = q_count - Q_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {core_dest, core_payload};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      q_count <= q_count_next;
    end
  end

  // First VC holding credit, scanning from the round-robin pointer.
  always_comb begin
    int                 idx;
    logic [VC_BITS-1:0] idx_v;
    any_credit = 1'b0;
    pick_vc    = '0;
    idx        = 0;
    idx_v      = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_VC) idx = idx - NUM_VC;
      idx_v = VC_BITS'(idx);
      if (!any_credit && credit_cnt[idx_v] != '0) begin
        any_credit = 1'b1;
        pick_vc    = idx_v;
      end
    end
  end

  assign send   = (state == S_SEND) && any_credit && (q_count != '0);
  assign rr_nxt = (pick_vc == VC_BITS'(NUM_VC - 1)) ? '0 : pick_vc + VC_BITS'(1);

  always_comb begin
    send_hit = '0;
    if (send) send_hit[pick_vc] = 1'b1;
  end

  // A return and a send on the same VC cancel; a return to a full counter
  // is dropped and flagged.
  always_comb begin
    credit_set_err  = 1'b0;
    any_credit_next = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      credit_nxt[v] = credit_cnt[v];
      if (credit_in[v] && !send_hit[v]) begin
        if (credit_cnt[v] == CR_MAX) credit_set_err = 1'b1;
        else                         credit_nxt[v]  = credit_cnt[v] + CR_ONE;
      end else if (!credit_in[v] && send_hit[v]) begin
        credit_nxt[v] = credit_cnt[v] - CR_ONE;
      end
      if (credit_nxt[v] != '0) any_credit_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) credit_cnt[v] <= CR_MAX;
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) credit_cnt[v] <= credit_nxt[v];
      if (credit_set_err) credit_err <= 1'b1;
    end
  end

  // ---------------- injection FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      inj_valid <= 1'b0;
      inj_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      inj_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (q_count != '0) state <= S_SEND;
        end
        S_SEND: begin
          if (send) begin
            inj_valid <= 1'b1;
            inj_data  <= {pick_vc, q_mem[rd_ptr]};
            rr_ptr    <= rr_nxt;
            if (q_count_next == '0)  state <= S_IDLE;
            else if (!any_credit_next) state <= S_BLOCKED;
          end else if (q_count == '0) begin
            state <= S_IDLE;
          end else if (!(|credit_in)) begin
            state <= S_BLOCKED;
          end
        end
        S_BLOCKED: begin
          if (|credit_in) state <= S_SEND;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- ejection ----------------
  logic [VC_BITS-1:0] unused_eject_vc;
  assign unused_eject_vc = eject_data_in[FLIT_W-1 -: VC_BITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eject_valid   <= 1'b0;
      eject_dest    <= '0;
      eject_payload <= '0;
    end else begin
      eject_valid <= eject_valid_in;
      if (eject_valid_in) begin
        eject_dest    <= eject_data_in[MSG_W-1:PAYLOAD_W];
        eject_payload <= eject_data_in[PAYLOAD_W-1:0];
      end
    end
  end

`ifdef NIC_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_count    <= '0;
      ej_count     <= '0;
      stall_cycles <= '0;
    end else begin
      inj_count <= inj_count + 32'(inj_valid);
      ej_count  <= ej_count + 32'(eject_valid);
      if (state == S_BLOCKED && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/nic_inject_eject.md
Name: nic_inject_eject

Overview:
- Local network interface attached to the router's local port (port 0).
- Injection side:
  - Accepts single-flit messages from the core on a valid/ready handshake and queues them.
  - Stamps each flit with an output VC chosen round-robin among VCs holding credit.
  - Drives the router's input_data[0]/input_valid[0].
- Ejection side: registers out_data[0]/out_valid[0] from the router and presents the flit to the core with the VC field stripped.

Parameters:
- NUM_VC, 4: VCs on the local input port.
- NUM_ROUTERS, 16: routers in the mesh.
- BUFFER_DEPTH, 8: router VC FIFO depth; this is the initial credit per VC (power of 2).
- INJ_DEPTH, 4: injection queue entries (power of 2, ≥2).
- VC_BITS, $clog2(NUM_VC): VC field width.
- ROUTER_ID_BITS, $clog2(NUM_ROUTERS): destination field width.
- CR_BITS, $clog2(BUFFER_DEPTH)+1: credit counter width.
- PAYLOAD_W, `FLIT_DATA_WIDTH-VC_BITS-ROUTER_ID_BITS: payload width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- core_valid  in  1  core offers a message.
- core_ready  out  1  NIC can accept (queue not full).
- core_dest  in  ROUTER_ID_BITS  destination router id.
- core_payload  in  PAYLOAD_W  message payload.
- inj_data  out  `FLIT_DATA_WIDTH  flit to router input_data[0].
- inj_valid  out  1  to router input_valid[0].
- credit_in  in  NUM_VC  one pulse per local-port VC slot freed in the router.
- eject_data_in  in  `FLIT_DATA_WIDTH  from router out_data[0].
- eject_valid_in  in  1  from router out_valid[0].
- eject_valid  out  1  ejected flit valid to core.
- eject_dest  out  ROUTER_ID_BITS  destination field of ejected flit.
- eject_payload  out  PAYLOAD_W  payload of ejected flit.
- credit_err  out  1  sticky: credit returned while counter already at BUFFER_DEPTH.

Behaviour:
- Flit format: [FLIT-1 -: VC_BITS] = VC id; next ROUTER_ID_BITS = dest; low PAYLOAD_W = payload.
- Reset (reset==0, async):
  - Queue empty; all credits = BUFFER_DEPTH; RR pointer = 0; FSM = IDLE.
  - inj_valid=0, inj_data=0, eject_valid=0, eject_dest=0, eject_payload=0, credit_err=0, core_ready=1.
  - Reset asserted mid-operation discards queued flits and in-flight credit state.
- Core handshake:
  - Message accepted when core_valid && core_ready.
  - core_ready = !queue_full; combinational from queue state only, never from core_valid.
  - Accept and pop in the same cycle while full: not allowed, core_ready stays 0 while full.
  - Accept and pop in the same cycle in all other cases: both take effect.
- FSM:
  - IDLE: queue empty. Go to SEND when the queue is non-empty.
  - SEND: queue head present and some VC has credit>0.
    - Pick VC = first VC with credit>0 starting at the RR pointer, wrapping around.
    - Register inj_data = {vc, dest, payload} and set inj_valid=1 for exactly one cycle.
    - Pop the head, decrement that VC's credit, and set RR pointer = vc+1 mod NUM_VC.
    - If the queue becomes empty, go to IDLE.
  - BLOCKED: queue non-empty and all credits 0.
    - inj_valid=0.
    - Return to SEND the cycle after any credit_in bit is seen.
- Latency: a message accepted at edge N into an empty queue with credit available appears with inj_valid=1 at edge N+2 (queue write, then registered send). Throughput is 1 flit/cycle while credits last.
- inj_valid deasserts in any cycle with no send; inj_data holds its last value.
- Credits:
  - Same-cycle credit_in[v] and send on v leaves the counter unchanged.
  - credit_in[v] with counter==BUFFER_DEPTH (and no send on v): counter saturates, credit_err sets and holds until reset.
  - Credit counter never goes below 0; no send occurs on a VC at 0.
- Ejection:
  - eject_valid, eject_dest, eject_payload are registered one cycle after eject_valid_in and the data.
  - eject_valid=0 when eject_valid_in=0; dest/payload then hold their previous value.
  - No backpressure: the core must sink every flit.

Optional Feature:
- NIC_STATS_EN defined:
  - Adds 32-bit outputs inj_count and ej_count. They increment on each inj_valid and eject_valid cycle and wrap at 2^32.
  - Adds a 16-bit stall_cycles output counting BLOCKED cycles; it saturates at 0xFFFF.
  - All three reset to 0.
- NIC_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, core sends dest=5, payload=0x12 in cycle 1 -> inj_valid=1 at edge 3, VC field=0, dest=5, payload=0x12; credit[0]=7.
- Four back-to-back messages, no credit_in -> VC fields 0,1,2,3 on consecutive cycles; core_ready never drops with INJ_DEPTH=4.
- Send 32 flits with no credit_in -> all credits 0, FSM BLOCKED, inj_valid=0, core_ready=0 after 4 further accepts. Pulse credit_in=4'b0100 -> next flit carries VC 2.
- credit_in[1] pulsed while credit[1]==8 -> credit_err=1 and stays 1; credit[1] stays 8.
- eject_valid_in=1 with a flit {vc=3, dest=9, payload=0xAB} -> next cycle eject_valid=1, eject_dest=9, eject_payload=0xAB; the cycle after, eject_valid=0.
- Assert reset with 3 flits queued and credit[2]=1 -> all outputs return to reset values immediately; after release all credits=8 and the queue is empty.
